// File: rtl/nand4_chk_pkg.sv
// Shared sizes and FSM encoding for the NAND4 response checker.
package nand4_chk_pkg;

    localparam int NUM_COMBOS = 16;
    localparam int STIM_W     = 4;
    localparam int RESP_W     = 3;
    localparam int FAIL_W     = STIM_W + RESP_W;

    // ST_WAIT is the post-check hold until the stimulus moves to a new vector.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_CHECK  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/nand4_ref_model.sv
// Combinational golden response of the NAND4 structure: two input NANDs feeding a third.
module nand4_ref_model
    import nand4_chk_pkg::*;
(
    input  logic [STIM_W-1:0] stim,
    output logic [RESP_W-1:0] resp
);

    logic e_exp;
    logic f_exp;
    logic g_exp;

    // stim is {a,b,c,d}, resp is {e,f,g}
    assign e_exp = ~(stim[3] & stim[2]);
    assign f_exp = ~(stim[1] & stim[0]);
    assign g_exp = ~(e_exp & f_exp);
    assign resp  = {e_exp, f_exp, g_exp};

endmodule

// File: rtl/nand4_resp_checker.sv
// Run-based checker for a NAND4 gate: waits for each new stimulus to settle, checks the
// response once, and tracks error count, first failure and stimulus coverage.
module nand4_resp_checker
    import nand4_chk_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 8,
    parameter int MAX_SAMPLES   = 1024
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             d,
    input  logic             e,
    input  logic             f,
    input  logic             g,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [6:0]       first_fail_vec,
    output logic             first_fail_valid,
    output logic [15:0]      coverage
);

    localparam logic [3:0]       SETTLE_INIT  = 4'(SETTLE_CYCLES);
    localparam logic [15:0]      SAMPLE_LIMIT = 16'(MAX_SAMPLES);
    localparam logic [ERR_W-1:0] ERR_SAT      = {ERR_W{1'b1}};

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (v == ERR_SAT) ? v : v + ERR_W'(1);
    endfunction

    logic [STIM_W-1:0]     stim_p0;
    logic [RESP_W-1:0]     resp_p0;
    logic [RESP_W-1:0]     resp_exp;

    state_t                state, state_nxt;
    logic [STIM_W-1:0]     stim_lat, stim_lat_nxt;
    logic [3:0]            settle_cnt, settle_cnt_nxt;
    logic [15:0]           sample_cnt, sample_cnt_nxt;
    logic [ERR_W-1:0]      err_cnt, err_cnt_nxt;
    logic [NUM_COMBOS-1:0] cov, cov_nxt;
    logic [FAIL_W-1:0]     ffv, ffv_nxt;
    logic                  ffvld, ffvld_nxt;

    logic                  stim_chg;
    logic                  mismatch;

    // Stage p0: every gate-side input is registered once before use.
    always_ff @(posedge clk) begin
        stim_p0 <= {a, b, c, d};
        resp_p0 <= {e, f, g};
    end

    nand4_ref_model u_ref (
        .stim (stim_lat),
        .resp (resp_exp)
    );

    assign stim_chg = (stim_p0 != stim_lat);
    assign mismatch = (resp_p0 != resp_exp);

    always_comb begin
        state_nxt      = state;
        stim_lat_nxt   = stim_lat;
        settle_cnt_nxt = settle_cnt;
        sample_cnt_nxt = sample_cnt;
        err_cnt_nxt    = err_cnt;
        cov_nxt        = cov;
        ffv_nxt        = ffv;
        ffvld_nxt      = ffvld;

        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nxt      = ST_SETTLE;
                    stim_lat_nxt   = stim_p0;
                    settle_cnt_nxt = SETTLE_INIT;
                    sample_cnt_nxt = '0;
                    err_cnt_nxt    = '0;
                    cov_nxt        = '0;
                    ffvld_nxt      = 1'b0;
                end
            end

            ST_SETTLE: begin
                if (stim_chg) begin
                    // abandon the old vector and restart settling on the new one
                    stim_lat_nxt   = stim_p0;
                    settle_cnt_nxt = SETTLE_INIT;
                end else begin
                    settle_cnt_nxt = settle_cnt - 4'd1;
                    if (settle_cnt <= 4'd1) begin
                        settle_cnt_nxt = '0;
                        state_nxt      = ST_CHECK;
                    end
                end
            end

            ST_CHECK: begin
                cov_nxt[stim_lat] = 1'b1;
                sample_cnt_nxt    = sample_cnt + 16'd1;
                if (mismatch) begin
                    err_cnt_nxt = sat_inc(err_cnt);
                    if (!ffvld) begin
                        ffv_nxt   = {stim_lat, resp_p0};
                        ffvld_nxt = 1'b1;
                    end
                end
                if ((&cov_nxt) || (sample_cnt_nxt == SAMPLE_LIMIT)) begin
                    state_nxt = ST_DONE;
                end else begin
                    state_nxt = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (stim_chg) begin
                    state_nxt      = ST_SETTLE;
                    stim_lat_nxt   = stim_p0;
                    settle_cnt_nxt = SETTLE_INIT;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Stage p1: run state and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            stim_lat   <= '0;
            settle_cnt <= '0;
            sample_cnt <= '0;
            err_cnt    <= '0;
            cov        <= '0;
            ffv        <= '0;
            ffvld      <= 1'b0;
        end else begin
            state      <= state_nxt;
            stim_lat   <= stim_lat_nxt;
            settle_cnt <= settle_cnt_nxt;
            sample_cnt <= sample_cnt_nxt;
            err_cnt    <= err_cnt_nxt;
            cov        <= cov_nxt;
            ffv        <= ffv_nxt;
            ffvld      <= ffvld_nxt;
        end
    end

    assign busy             = (state == ST_SETTLE) || (state == ST_CHECK) || (state == ST_WAIT);
    assign done             = (state == ST_DONE);
    assign pass             = done && (err_cnt == '0) && (&cov);
    assign err_count        = err_cnt;
    assign coverage         = cov;
    assign first_fail_vec   = ffv;
    assign first_fail_valid = ffvld;

endmodule

// File: tb/tb_nand4_resp_checker.sv
// Scoreboard bench for nand4_resp_checker: three instances (default, small budget, narrow counter).
`timescale 1ns/1ps
module tb_nand4_resp_checker;

    localparam int SETTLED_HOLD = 4;

    typedef struct {
        bit ok_pass;
        int err;
        int cov;
        int ffv;
        bit ffvld;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0;
    logic e, f, g;
    logic start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
    int   fault_sel = 0;

    logic busy0, done0, pass0, ffvld0;
    logic busy1, done1, pass1, ffvld1;
    logic busy2, done2, pass2, ffvld2;
    logic [7:0]  err0, err1;
    logic [1:0]  err2;
    logic [6:0]  ffv0, ffv1, ffv2;
    logic [15:0] cov0, cov1, cov2;
    logic done0_q = 1'b0, done1_q = 1'b0, done2_q = 1'b0;

    int n_checks = 0;
    int n_err = 0;
    int seq_v[$];
    int seq_h[$];
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    always #5 clk = ~clk;

    // Gate under test: fault 1 = g stuck at 0, fault 2 = f inverted.
    function automatic logic [2:0] gate_resp(input int v, input int flt);
        bit av, bv, cv, dv, ev, fv, gv;
        av = v[3]; bv = v[2]; cv = v[1]; dv = v[0];
        ev = !(av && bv);
        fv = !(cv && dv);
        gv = !(ev && fv);
        if (flt == 1) gv = 1'b0;
        if (flt == 2) fv = !fv;
        return {ev, fv, gv};
    endfunction

    assign {e, f, g} = gate_resp(int'({a, b, c, d}), fault_sel);

    nand4_resp_checker u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .first_fail_vec(ffv0),
        .first_fail_valid(ffvld0), .coverage(cov0));

    nand4_resp_checker #(.MAX_SAMPLES(4)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .first_fail_vec(ffv1),
        .first_fail_valid(ffvld1), .coverage(cov1));

    nand4_resp_checker #(.ERR_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2), .first_fail_vec(ffv2),
        .first_fail_valid(ffvld2), .coverage(cov2));

    task automatic chk(input string nm, input longint got, input longint want);
        n_checks++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, want);
        end
    endtask

    // Reference: every vector held for the full settle window is checked once, in order,
    // until all 16 combinations are seen or the sample budget is used up.
    function automatic exp_t model(input int err_w, input int max_s, input int flt);
        exp_t r;
        int n;
        int emax;
        logic [2:0] want, got;
        r = '{default: 0};
        emax = (1 << err_w) - 1;
        n = 0;
        foreach (seq_v[i]) begin
            if (seq_h[i] < SETTLED_HOLD) continue;
            want = gate_resp(seq_v[i], 0);
            got  = gate_resp(seq_v[i], flt);
            if (want != got) begin
                if (r.err < emax) r.err++;
                if (!r.ffvld) begin
                    r.ffvld = 1'b1;
                    r.ffv   = (seq_v[i] << 3) | int'(got);
                end
            end
            r.cov = r.cov | (1 << seq_v[i]);
            n++;
            if (r.cov == 16'hFFFF || n == max_s) break;
        end
        r.ok_pass = (r.err == 0) && (r.cov == 16'hFFFF);
        return r;
    endfunction

    function automatic int qsize(input int inst);
        case (inst)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic qpush(input int inst, input exp_t ex);
        case (inst)
            0: q0.push_back(ex);
            1: q1.push_back(ex);
            default: q2.push_back(ex);
        endcase
    endtask

    task automatic qpop(input int inst, output exp_t ex);
        case (inst)
            0: ex = q0.pop_front();
            1: ex = q1.pop_front();
            default: ex = q2.pop_front();
        endcase
    endtask

    task automatic mon_check(input int inst, input string nm, input bit p, input int er,
                             input int cv, input int fv, input bit fvl);
        exp_t ex;
        if (qsize(inst) == 0) begin
            chk({nm, ".unexpected_done"}, 1, 0);
            return;
        end
        qpop(inst, ex);
        chk({nm, ".pass"}, p, ex.ok_pass);
        chk({nm, ".err_count"}, er, ex.err);
        chk({nm, ".coverage"}, cv, ex.cov);
        chk({nm, ".first_fail_valid"}, fvl, ex.ffvld);
        if (ex.ffvld) chk({nm, ".first_fail_vec"}, fv, ex.ffv);
    endtask

    // Monitors: a rising done is the DUT presenting a run result.
    always @(negedge clk) begin
        if (done0 && !done0_q) mon_check(0, "dut0", pass0, int'(err0), int'(cov0), int'(ffv0), ffvld0);
        if (done1 && !done1_q) mon_check(1, "dut1", pass1, int'(err1), int'(cov1), int'(ffv1), ffvld1);
        if (done2 && !done2_q) mon_check(2, "dut2", pass2, int'(err2), int'(cov2), int'(ffv2), ffvld2);
        done0_q <= done0;
        done1_q <= done1;
        done2_q <= done2;
    end

    task automatic set_start(input int inst, input logic v);
        case (inst)
            0: start0 = v;
            1: start1 = v;
            default: start2 = v;
        endcase
    endtask

    task automatic add(input int v, input int h);
        seq_v.push_back(v);
        seq_h.push_back(h);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int inst, input int flt, input int poke_at);
        exp_t ex;
        int cyc;
        fault_sel = flt;
        case (inst)
            0: ex = model(8, 1024, flt);
            1: ex = model(8, 4, flt);
            default: ex = model(2, 1024, flt);
        endcase
        qpush(inst, ex);
        {a, b, c, d} = 4'(seq_v[0]);
        repeat (2) tick();
        cyc = 0;
        foreach (seq_v[i]) begin
            {a, b, c, d} = 4'(seq_v[i]);
            for (int h = 0; h < seq_h[i]; h++) begin
                set_start(inst, (i == 0 && h == 0) || (cyc == poke_at));
                tick();
                cyc++;
            end
        end
        set_start(inst, 1'b0);
        for (int t = 0; t < 200; t++) begin
            if (qsize(inst) == 0) break;
            tick();
        end
        chk("result_drained", qsize(inst), 0);
        while (qsize(inst) != 0) qpop(inst, ex);
    endtask

    task automatic make_sweep(input int hmin, input int hmax);
        for (int v = 0; v < 16; v++) add(v, $urandom_range(hmin, hmax));
    endtask

    initial begin
        int n, v, prev;
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, v, prev;
        bit settled;

        // reset
        rst = 1'b1;
        repeat (2) tick();
        chk("rst.busy", busy0, 0);
        chk("rst.done", done0, 0);
        chk("rst.pass", pass0, 0);
        chk("rst.err_count", err0, 0);
        chk("rst.coverage", cov0, 0);
        chk("rst.first_fail_vec", ffv0, 0);
        chk("rst.first_fail_valid", ffvld0, 0);
        chk("rst.dut1.done", done1, 0);
        chk("rst.dut2.busy", busy2, 0);
        rst = 1'b0;
        tick();

        // exhaustive, correct gate
        seq_v.delete(); seq_h.delete();
        make_sweep(4, 4);
        run(0, 0, -1);
        chk("exh.done", done0, 1);

        // exhaustive, g stuck at 0
        seq_v.delete(); seq_h.delete();
        make_sweep(4, 4);
        run(0, 1, -1);
        chk("sa0.err_count", err0, 7);
        chk("sa0.first_fail_vec", ffv0, 7'b0011_100);
        chk("sa0.first_fail_valid", ffvld0, 1);
        chk("sa0.pass", pass0, 0);

        // randomized runs: random prefix with occasional short-lived vectors, then a full sweep
        for (int r = 0; r < 6; r++) begin
            seq_v.delete(); seq_h.delete();
            n = $urandom_range(0, 8);
            prev = -1;
            for (int k = 0; k < n; k++) begin
                do v = $urandom_range(0, 15);
                while (v == prev || (k == n - 1 && v == 0));
                settled = (k == 0) || ($urandom_range(0, 3) != 0);
                add(v, settled ? $urandom_range(4, 6) : 2);
                prev = v;
            end
            make_sweep(4, 6);
            run(0, $urandom_range(0, 2), -1);
        end

        // budget of 4 with a settle restart: vector 9 is replaced one cycle into SETTLE
        seq_v.delete(); seq_h.delete();
        add(5, 4); add(9, 2); add(10, 4); add(3, 4); add(12, 4); add(7, 4);
        run(1, 0, -1);
        chk("budget.done", done1, 1);
        chk("budget.popcount", $countones(cov1), 4);
        chk("budget.cov_abandoned", cov1[9], 0);
        chk("budget.cov_restarted", cov1[10], 1);

        // narrow error counter saturates; start mid-run is ignored
        seq_v.delete(); seq_h.delete();
        make_sweep(4, 4);
        run(2, 1, 30);
        chk("sat.err_count", err2, 3);
        chk("sat.coverage", cov2, 16'hFFFF);

        // reset mid-run discards the run; rst wins over start
        fault_sel = 1;
        {a, b, c, d} = 4'd3;
        repeat (2) tick();
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        repeat (4) tick();
        {a, b, c, d} = 4'd7;
        repeat (2) tick();
        chk("midrst.busy_before", busy0, 1);
        rst = 1'b1;
        start0 = 1'b1;
        tick();
        chk("midrst.busy", busy0, 0);
        chk("midrst.done", done0, 0);
        chk("midrst.err_count", err0, 0);
        chk("midrst.coverage", cov0, 0);
        chk("midrst.first_fail_valid", ffvld0, 0);
        rst = 1'b0;
        start0 = 1'b0;
        tick();
        chk("midrst.idle_after", busy0, 0);

        // recovery run after the reset
        seq_v.delete(); seq_h.delete();
        make_sweep(4, 5);
        run(0, 0, -1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
